// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared RV32I pipeline types: opcodes, funct3 widths, stage registers, mem FSM state
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
        logic [3:0]  regfilemux_sel;
        logic        regf_we;
        logic [4:0]  dest_arch;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic        br_en;
        logic [31:0] u_imm;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
        logic [3:0]  regfilemux_sel;
        logic        regf_we;
        logic [4:0]  dest_arch;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic        br_en;
        logic [31:0] u_imm;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
    } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_stage_lane_gen.sv
// rtl/mem_stage_lane_gen.sv - byte-lane mask and store-data alignment for one data-memory access
module mem_lane_gen (
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_v,
    input  logic        is_load,
    input  logic        is_store,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata
);

    logic [3:0] mask;

    always_comb begin
        mask = 4'b0000;
        case (size)
            2'b00:   mask = 4'b0001 << addr_lo;
            2'b01:   mask = 4'b0011 << {addr_lo[1], 1'b0};
            default: mask = 4'b1111;
        endcase
        rmask = is_load ? mask : 4'b0000;
        wmask = is_store ? mask : 4'b0000;
        wdata = is_store ? (rs2_v << {addr_lo, 3'b000}) : 32'h0;
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory stage: dmem request, outstanding-access freeze, mem_wb register
// Optional misaligned-access suppression with misalign_err port when MEM_MISALIGN_CHECK_EN is defined.
module mem_stage
    import rv32i_types::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ex_mem_stage_reg_t      ex_mem,
    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_rmask,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    input  logic                   dmem_resp,
    output logic                   freeze_stall,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                   misalign_err,
`endif
    output mem_wb_stage_reg_t      mem_wb,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    mem_state_t state, state_next;
    logic       is_load, is_store, mem_op, misaligned, issue;
    logic [3:0] lane_rmask, lane_wmask;
    logic [31:0] lane_wdata;

    assign is_load  = ex_mem.valid && (ex_mem.opcode == op_load);
    assign is_store = ex_mem.valid && (ex_mem.opcode == op_store);
    assign mem_op   = is_load || is_store;

`ifdef MEM_MISALIGN_CHECK_EN
    // funct3[1:0]: 00 byte (never misaligned), 01 half, 1x word
    assign misaligned = mem_op &&
        (((ex_mem.funct3[1:0] == 2'b01) && ex_mem.alu_out[0]) ||
         (ex_mem.funct3[1] && (ex_mem.alu_out[1:0] != 2'b00)));
    assign misalign_err = misaligned && !freeze_stall;
`else
    assign misaligned = 1'b0;
`endif

    mem_lane_gen u_lane_gen (
        .size     (ex_mem.funct3[1:0]),
        .addr_lo  (ex_mem.alu_out[1:0]),
        .rs2_v    (ex_mem.rs2_v),
        .is_load  (is_load),
        .is_store (is_store),
        .rmask    (lane_rmask),
        .wmask    (lane_wmask),
        .wdata    (lane_wdata)
    );

    assign freeze_stall = (state == WAIT) && !dmem_resp;
    assign issue        = mem_op && !misaligned && !freeze_stall;

    assign dmem_addr  = {ex_mem.alu_out[31:2], 2'b00};
    assign dmem_rmask = issue ? lane_rmask : 4'b0000;
    assign dmem_wmask = issue ? lane_wmask : 4'b0000;
    assign dmem_wdata = misaligned ? 32'h0 : lane_wdata;

    // A response in WAIT frees the stage; a new request that same cycle keeps us waiting
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = WAIT;
            WAIT:    if (dmem_resp) state_next = issue ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            mem_wb       <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if (freeze_stall) begin
                if (stall_cycles != {STALL_CNT_W{1'b1}})
                    stall_cycles <= stall_cycles + 1'b1;
            end else begin
                mem_wb.valid          <= ex_mem.valid;
                mem_wb.pc             <= ex_mem.pc;
                mem_wb.inst           <= ex_mem.inst;
                mem_wb.opcode         <= ex_mem.opcode;
                mem_wb.funct3         <= ex_mem.funct3;
                mem_wb.alu_out        <= ex_mem.alu_out;
                mem_wb.rs2_v          <= ex_mem.rs2_v;
                mem_wb.regfilemux_sel <= ex_mem.regfilemux_sel;
                mem_wb.regf_we        <= ex_mem.regf_we && !misaligned;
                mem_wb.dest_arch      <= ex_mem.dest_arch;
                mem_wb.rs1_s          <= ex_mem.rs1_s;
                mem_wb.rs2_s          <= ex_mem.rs2_s;
                mem_wb.br_en          <= ex_mem.br_en;
                mem_wb.u_imm          <= ex_mem.u_imm;
                mem_wb.dmem_addr      <= mem_op ? ex_mem.alu_out : 32'h0;
                mem_wb.dmem_rmask     <= dmem_rmask;
                mem_wb.dmem_wmask     <= dmem_wmask;
                mem_wb.dmem_wdata     <= dmem_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (MEM_MISALIGN_CHECK_EN optional)
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk;
    logic              rst;
    ex_mem_stage_reg_t ex_mem;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic              dmem_resp;
    logic              freeze_stall;
`ifdef MEM_MISALIGN_CHECK_EN
    logic              misalign_err;
`endif
    mem_wb_stage_reg_t mem_wb;
    logic [31:0]       stall_cycles;

    int n_checks = 0;
    int n_errors = 0;
    int seen_stall = 0;

    mem_stage #(.STALL_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_mem       (ex_mem),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_resp    (dmem_resp),
        .freeze_stall (freeze_stall),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_err (misalign_err),
`endif
        .mem_wb       (mem_wb),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_stage_reg_t mk(input rv32i_opcode op, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] data,
                                             input logic [31:0] pc);
        ex_mem_stage_reg_t r;
        r         = '0;
        r.valid   = 1'b1;
        r.pc      = pc;
        r.opcode  = op;
        r.funct3  = f3;
        r.alu_out = addr;
        r.rs2_v   = data;
        r.regf_we = (op != op_store);
        r.dest_arch = 5'd3;
        return r;
    endfunction

    initial begin
        rst       = 1'b0;
        dmem_resp = 1'b0;
        ex_mem    = '0;
        tick();
        tick();
        check("rst_mem_wb_valid", {31'b0, mem_wb.valid}, 32'd0);
        check("rst_mem_wb_pc", mem_wb.pc, 32'd0);
        check("rst_stall_cycles", stall_cycles, 32'd0);
        check("rst_freeze", {31'b0, freeze_stall}, 32'd0);
        rst = 1'b1;

        // non-memory op: no request, reaches mem_wb one cycle later
        ex_mem = mk(op_imm, 3'b000, 32'h0000_0055, 32'h0, 32'h0000_0010);
        #1;
        check("alu_rmask", {28'b0, dmem_rmask}, 32'd0);
        check("alu_wmask", {28'b0, dmem_wmask}, 32'd0);
        tick();
        check("alu_wb_valid", {31'b0, mem_wb.valid}, 32'd1);
        check("alu_wb_pc", mem_wb.pc, 32'h0000_0010);
        check("alu_wb_dmem_addr", mem_wb.dmem_addr, 32'd0);

        // SW at byte offset 2: word mask, data shifted by 16
        ex_mem = mk(op_store, 3'b010, 32'h1000_0006, 32'hAABB_CCDD, 32'h0000_0100);
        #1;
        check("sw_addr", dmem_addr, 32'h1000_0004);
        check("sw_wmask", {28'b0, dmem_wmask}, 32'h0000_000F);
        check("sw_rmask", {28'b0, dmem_rmask}, 32'd0);
        check("sw_wdata", dmem_wdata, 32'hCCDD_0000);
        tick();
        ex_mem    = '0;
        dmem_resp = 1'b1;
        #1;
        check("sw_freeze", {31'b0, freeze_stall}, 32'd0);
        check("sw_wb_addr", mem_wb.dmem_addr, 32'h1000_0006);
        check("sw_wb_wmask", {28'b0, mem_wb.dmem_wmask}, 32'h0000_000F);
        tick();
        dmem_resp = 1'b0;
        check("bubble_wb_valid", {31'b0, mem_wb.valid}, 32'd0);

        // SB then SH back-to-back
        ex_mem = mk(op_store, 3'b000, 32'h0000_2003, 32'h0000_0011, 32'h0000_0104);
        #1;
        check("sb_wmask", {28'b0, dmem_wmask}, 32'h0000_0008);
        check("sb_wdata", dmem_wdata, 32'h1100_0000);
        tick();
        ex_mem    = mk(op_store, 3'b001, 32'h0000_2002, 32'h0000_1234, 32'h0000_0108);
        dmem_resp = 1'b1;
        #1;
        check("sh_freeze", {31'b0, freeze_stall}, 32'd0);
        check("sh_wmask", {28'b0, dmem_wmask}, 32'h0000_000C);
        check("sh_wdata", dmem_wdata, 32'h1234_0000);
        check("sh_addr", dmem_addr, 32'h0000_2000);
        tick();
        ex_mem = mk(op_load, 3'b100, 32'h0000_2001, 32'h0, 32'h0000_010C);
        #1;
        check("lbu_rmask", {28'b0, dmem_rmask}, 32'h0000_0002);
        check("lbu_wmask", {28'b0, dmem_wmask}, 32'd0);
        check("lbu_wdata", dmem_wdata, 32'd0);
        tick();
        ex_mem = '0;
        tick();
        dmem_resp = 1'b0;
        check("pre_lw_stall", stall_cycles, 32'd0);

        // LW with response three cycles late
        ex_mem = mk(op_load, 3'b010, 32'h0000_3000, 32'h0, 32'h0000_0200);
        #1;
        check("lw_rmask", {28'b0, dmem_rmask}, 32'h0000_000F);
        tick();
        ex_mem = mk(op_imm, 3'b000, 32'h0000_0077, 32'h0, 32'h0000_0204);
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_freeze", {31'b0, freeze_stall}, 32'd1);
            check("lw_wait_rmask", {28'b0, dmem_rmask}, 32'd0);
            check("lw_wait_wb_pc", mem_wb.pc, 32'h0000_0200);
            if (freeze_stall) seen_stall++;
            tick();
        end
        dmem_resp = 1'b1;
        #1;
        check("lw_resp_freeze", {31'b0, freeze_stall}, 32'd0);
        tick();
        dmem_resp = 1'b0;
        ex_mem    = '0;
        check("lw_next_wb_pc", mem_wb.pc, 32'h0000_0204);
        check("lw_stall_cycles", stall_cycles, seen_stall);
        check("lw_stall_abs", stall_cycles, 32'd3);

        // back-to-back loads with immediate responses
        ex_mem = mk(op_load, 3'b010, 32'h0000_4000, 32'h0, 32'h0000_0300);
        #1;
        check("b2b_lw1_rmask", {28'b0, dmem_rmask}, 32'h0000_000F);
        tick();
        ex_mem    = mk(op_load, 3'b001, 32'h0000_4006, 32'h0, 32'h0000_0304);
        dmem_resp = 1'b1;
        #1;
        check("b2b_lw2_freeze", {31'b0, freeze_stall}, 32'd0);
        check("b2b_lw2_rmask", {28'b0, dmem_rmask}, 32'h0000_000C);
        check("b2b_lw2_addr", dmem_addr, 32'h0000_4004);
        tick();
        ex_mem = '0;
        #1;
        check("b2b_wait_freeze", {31'b0, freeze_stall}, 32'd0);
        check("b2b_wb_pc", mem_wb.pc, 32'h0000_0304);
        tick();
        dmem_resp = 1'b0;
        #1;
        check("b2b_idle_freeze", {31'b0, freeze_stall}, 32'd0);
        check("b2b_stall_cycles", stall_cycles, 32'd3);

        // reset while waiting, then a stray response
        ex_mem = mk(op_load, 3'b010, 32'h0000_5000, 32'h0, 32'h0000_0400);
        tick();
        ex_mem = '0;
        #1;
        check("rw_freeze_before", {31'b0, freeze_stall}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rw_freeze_after", {31'b0, freeze_stall}, 32'd0);
        check("rw_wb_valid", {31'b0, mem_wb.valid}, 32'd0);
        check("rw_stall_cycles", stall_cycles, 32'd0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        check("stray_freeze", {31'b0, freeze_stall}, 32'd0);
        ex_mem = mk(op_load, 3'b010, 32'h0000_5004, 32'h0, 32'h0000_0404);
        #1;
        check("stray_lw_rmask", {28'b0, dmem_rmask}, 32'h0000_000F);
        tick();
        ex_mem = '0;
        check("stray_lw_freeze", {31'b0, freeze_stall}, 32'd1);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;

        // misaligned word load
        ex_mem = mk(op_load, 3'b010, 32'h0000_3001, 32'h0, 32'h0000_0500);
        #1;
`ifdef MEM_MISALIGN_CHECK_EN
        check("mis_rmask", {28'b0, dmem_rmask}, 32'd0);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        tick();
        ex_mem = '0;
        #1;
        check("mis_err_clear", {31'b0, misalign_err}, 32'd0);
        check("mis_wb_valid", {31'b0, mem_wb.valid}, 32'd1);
        check("mis_wb_we", {31'b0, mem_wb.regf_we}, 32'd0);
        check("mis_freeze", {31'b0, freeze_stall}, 32'd0);
`else
        check("mis_rmask", {28'b0, dmem_rmask}, 32'h0000_000F);
        check("mis_addr", dmem_addr, 32'h0000_3000);
        tick();
        ex_mem = '0;
        #1;
        check("mis_wb_we", {31'b0, mem_wb.regf_we}, 32'd1);
        check("mis_freeze", {31'b0, freeze_stall}, 32'd1);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
